sim_uart_in_feeder: RTL and testbench
=====================================

# sim_uart_in_feeder

Simulation-only character source for the SoC UART receive path. It is the input-side counterpart of the UART output capture in the simulation top. Host-side code (DPI or a bench) pushes characters into an internal FIFO. The DUT pulls them one per read strobe on its `io_uart_in` interface, and gets 8'hff whenever no character is available. An end-of-input marker lets the host signal that the workload's stdin is exhausted.

## Interface
Parameters:
- `DEPTH`, default 16: FIFO entries; power of two, ≥ 2.
- `CNT_W`, default `$clog2(DEPTH)+1`: occupancy counter width; derived, do not override.

Ports:
- `clock`  in  1  sim clock; all state is updated on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `push_valid`  in  1  host offers `push_ch`.
- `push_ready`  out  1  FIFO can accept a character; high when occupancy < DEPTH.
- `push_ch`  in  8  character from the host.
- `push_eof`  in  1  single-cycle pulse: the host has no more input.
- `uart_in_valid`  in  1  DUT read strobe (SimTop `io_uart_in_valid`).
- `uart_in_ch`  out  8  character returned to the DUT (SimTop `io_uart_in_ch`).
- `level`  out  CNT_W  current FIFO occupancy.
- `eof_reached`  out  1  EOF has been latched and the FIFO is empty.
- `reads_no_char`  out  32  count of strobes answered with 8'hff.

## Operation
- Push: a character is written when `push_valid && push_ready` at a rising edge.
- Read:
  - `uart_in_ch` = FIFO head when non-empty, else 8'hff. It is combinational from the state and does not depend on `uart_in_valid`.
  - When `uart_in_valid` is high at a rising edge and the FIFO is non-empty, the head is popped.
  - When `uart_in_valid` is high and the FIFO is empty, nothing is popped and `reads_no_char` increments, saturating at 32'hffffffff.
- EOF state machine, states `RUN`, `DRAIN`, `DONE`:
  - `RUN` → `DRAIN` on `push_eof`.
  - `DRAIN` → `DONE` when the FIFO is empty. This can happen in the same cycle as the EOF pulse if the FIFO is empty then.
  - `DONE` is terminal until reset.
  - In `DRAIN` and `DONE`, `push_ready` = 0 and pushes are ignored.
  - `eof_reached` = 1 only in `DONE`.
- Pointers: read and write pointers are `$clog2(DEPTH)` bits and wrap naturally. Occupancy is tracked in a separate counter of `CNT_W` bits.

## Timing
- Reset values:
  - `push_ready` = 1.
  - `uart_in_ch` = 8'hff.
  - `level` = 0.
  - `eof_reached` = 0.
  - `reads_no_char` = 0.
  - State = `RUN`; pointers = 0.
- Push-to-visible latency: a character pushed at edge N appears on `uart_in_ch` after edge N. A strobe in the same cycle as a push into an empty FIFO sees 8'hff.
- Simultaneous push and pop:
  - Not full: both happen and `level` is unchanged.
  - Full: `push_ready` is low, so only the pop occurs. `push_ready` rises after that edge.
- Reset asserted mid-operation clears all state immediately. Buffered characters are discarded and `uart_in_ch` returns to 8'hff without waiting for a clock edge.
- Combinational paths:
  - `push_ready` depends only on registered state.
  - There is no combinational path from `uart_in_valid` to any output.

## Configuration
- `SIM_UART_IN_ECHO_EN` defined:
  - Adds output ports `echo_valid` (1 bit) and `echo_ch` (8 bits).
  - `echo_valid` is a registered pulse one cycle after each successful pop, with `echo_ch` = the popped character.
  - Both reset to 0.
  - The sim top prints them so console input is mirrored in the log.
- Undefined: the ports and logic are absent.

## Structure
- Package `sim_uart_pkg` holds:
  - `UART_NO_CHAR` = 8'hff.
  - The enum `feeder_state_t` {`RUN`, `DRAIN`, `DONE`}.
- Sub-module `sim_uart_fifo`:
  - Parameterised synchronous FIFO providing `level`, `full`, `empty`, head data and push/pop.
  - The feeder adds the EOF FSM, the no-char counter and the echo logic around it.

## Test plan
- Basic read-out: after reset, push 8'h41, 8'h42; strobe 3 cycles → `uart_in_ch` shows 41, 42, ff; `reads_no_char` = 1; `level` ends at 0.
- Backpressure: with `DEPTH`=16, push 17 characters back-to-back → `push_ready` low after the 16th; the 17th is held until one strobe pops; the order of all 17 is preserved.
- Full-FIFO simultaneous push and pop: 16 entries and a strobe with `push_valid` high → one pop, no push, `level` = 15; the next cycle's push is accepted.
- Wrap-around: 40 interleaved push/pop pairs → output sequence matches input exactly; pointers wrap twice.
- EOF: push 3 characters, then pulse `push_eof` → `push_ready` drops and a 4th push is ignored; after 3 strobes, `eof_reached` = 1 and `uart_in_ch` = ff.
- Async reset and echo:
  - Assert `reset` mid-stream between edges → outputs return to reset values at once.
  - With `SIM_UART_IN_ECHO_EN`, each pop yields `echo_valid` one cycle later carrying the same character.

Source files
------------

// File: rtl/sim_uart_pkg.sv
// rtl/sim_uart_pkg.sv - shared constants and types for the simulation UART input feeder
package sim_uart_pkg;

  localparam logic [7:0] UART_NO_CHAR = 8'hff;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } feeder_state_t;

endpackage

// File: rtl/sim_uart_fifo.sv
// rtl/sim_uart_fifo.sv - synchronous character FIFO with occupancy counter
module sim_uart_fifo #(
  parameter int DEPTH = 16,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [7:0]       push_data,
  input  logic             pop,
  output logic [7:0]       head,
  output logic [CNT_W-1:0] level,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] level_q, level_d;
  logic [7:0]       mem_q [DEPTH];
  logic [7:0]       mem_d [DEPTH];
  logic             push_ok;
  logic             pop_ok;

  assign full    = (level_q == CNT_W'(DEPTH));
  assign empty   = (level_q == '0);
  assign head    = mem_q[rd_ptr_q];
  assign level   = level_q;
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push_ok, pop_ok})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage is never visible while empty, so it needs no reset.
  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/sim_uart_in_feeder.sv
// rtl/sim_uart_in_feeder.sv - host-fed character source for the UART receive path
// Optional echo of popped characters: SIM_UART_IN_ECHO_EN
module sim_uart_in_feeder
  import sim_uart_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push_valid,
  output logic             push_ready,
  input  logic [7:0]       push_ch,
  input  logic             push_eof,
  input  logic             uart_in_valid,
  output logic [7:0]       uart_in_ch,
  output logic [CNT_W-1:0] level,
  output logic             eof_reached,
  output logic [31:0]      reads_no_char
`ifdef SIM_UART_IN_ECHO_EN
  ,
  output logic             echo_valid,
  output logic [7:0]       echo_ch
`endif
);

  feeder_state_t state_q, state_d;
  logic [31:0]   reads_no_char_q, reads_no_char_d;
  logic          fifo_full;
  logic          fifo_empty;
  logic [7:0]    fifo_head;
  logic          push_fire;
  logic          pop_fire;
  logic          drained;

  sim_uart_fifo #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push_fire),
    .push_data (push_ch),
    .pop       (pop_fire),
    .head      (fifo_head),
    .level     (level),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign push_fire     = push_valid && push_ready;
  assign pop_fire      = uart_in_valid && !fifo_empty;
  assign uart_in_ch    = fifo_empty ? UART_NO_CHAR : fifo_head;
  assign reads_no_char = reads_no_char_q;

  // True when the FIFO will be empty after this edge.
  assign drained = ((level == '0) && !push_fire) ||
                   ((level == CNT_W'(1)) && pop_fire && !push_fire);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (push_eof) state_d = drained ? DONE : DRAIN;
      DRAIN:   if (drained)  state_d = DONE;
      DONE:    state_d = DONE;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    push_ready  = (state_q == RUN) && !fifo_full;
    eof_reached = (state_q == DONE);
  end

  always_comb begin
    reads_no_char_d = reads_no_char_q;
    if (uart_in_valid && fifo_empty && (reads_no_char_q != 32'hffff_ffff)) begin
      reads_no_char_d = reads_no_char_q + 32'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      reads_no_char_q <= '0;
    end else begin
      reads_no_char_q <= reads_no_char_d;
    end
  end

`ifdef SIM_UART_IN_ECHO_EN
  logic       echo_valid_q, echo_valid_d;
  logic [7:0] echo_ch_q, echo_ch_d;

  always_comb begin
    echo_valid_d = pop_fire;
    echo_ch_d    = pop_fire ? fifo_head : echo_ch_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      echo_valid_q <= 1'b0;
      echo_ch_q    <= 8'h00;
    end else begin
      echo_valid_q <= echo_valid_d;
      echo_ch_q    <= echo_ch_d;
    end
  end

  assign echo_valid = echo_valid_q;
  assign echo_ch    = echo_ch_q;
`endif

endmodule

// File: tb/tb_sim_uart_in_feeder.sv
// tb/tb_sim_uart_in_feeder.sv - scoreboard bench for sim_uart_in_feeder
module tb_sim_uart_in_feeder;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        push_valid = 1'b0;
  logic        push_ready;
  logic [7:0]  push_ch = 8'h00;
  logic        push_eof = 1'b0;
  logic        uart_in_valid = 1'b0;
  logic [7:0]  uart_in_ch;
  logic [4:0]  level;
  logic        eof_reached;
  logic [31:0] reads_no_char;
`ifdef SIM_UART_IN_ECHO_EN
  logic        echo_valid;
  logic [7:0]  echo_ch;
  logic [7:0]  echo_q [$];
`endif

  int          errors = 0;
  int          checks = 0;
  logic [7:0]  exp_q [$];
  logic [7:0]  mon_e;

  sim_uart_in_feeder #(.DEPTH(16)) dut (
    .clock         (clock),
    .reset         (reset),
    .push_valid    (push_valid),
    .push_ready    (push_ready),
    .push_ch       (push_ch),
    .push_eof      (push_eof),
    .uart_in_valid (uart_in_valid),
    .uart_in_ch    (uart_in_ch),
    .level         (level),
    .eof_reached   (eof_reached),
    .reads_no_char (reads_no_char)
`ifdef SIM_UART_IN_ECHO_EN
    ,
    .echo_valid    (echo_valid),
    .echo_ch       (echo_ch)
`endif
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push1(input logic [7:0] c);
    push_valid = 1'b1;
    push_ch    = c;
    tick();
    push_valid = 1'b0;
  endtask

  task automatic strobe(input logic [7:0] e);
    exp_q.push_back(e);
    uart_in_valid = 1'b1;
    tick();
    uart_in_valid = 1'b0;
  endtask

  // Monitor: every strobe cycle is compared against the next queued expectation.
  always @(negedge clock) begin
`ifdef SIM_UART_IN_ECHO_EN
    if (!reset && echo_valid) begin
      if (echo_q.size() == 0) begin
        check("echo_unexpected", 32'(echo_ch), 32'h100);
      end else begin
        check("echo_ch", 32'(echo_ch), 32'(echo_q.pop_front()));
      end
    end
`endif
    if (!reset && uart_in_valid) begin
      if (exp_q.size() == 0) begin
        check("rd_unexpected", 32'(uart_in_ch), 32'h100);
      end else begin
        mon_e = exp_q.pop_front();
        check("rd_ch", 32'(uart_in_ch), 32'(mon_e));
`ifdef SIM_UART_IN_ECHO_EN
        if (mon_e != 8'hff) echo_q.push_back(mon_e);
`endif
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 reset = 1'b1;
    #2;
    check("rst_push_ready", 32'(push_ready), 32'd1);
    check("rst_uart_in_ch", 32'(uart_in_ch), 32'hff);
    check("rst_level", 32'(level), 32'd0);
    check("rst_eof", 32'(eof_reached), 32'd0);
    check("rst_reads", reads_no_char, 32'd0);
    repeat (2) tick();
    reset = 1'b0;
    tick();

    // Basic read-out
    push1(8'h41);
    check("basic_head", 32'(uart_in_ch), 32'h41);
    push1(8'h42);
    check("basic_level2", 32'(level), 32'd2);
    strobe(8'h41);
    strobe(8'h42);
    strobe(8'hff);
    check("basic_reads", reads_no_char, 32'd1);
    check("basic_level0", 32'(level), 32'd0);

    // Strobe in the same cycle as a push into an empty FIFO sees no character
    push_valid = 1'b1;
    push_ch    = 8'h55;
    strobe(8'hff);
    push_valid = 1'b0;
    check("same_cycle_level", 32'(level), 32'd1);
    check("same_cycle_reads", reads_no_char, 32'd2);
    strobe(8'h55);

    // Backpressure and full-FIFO simultaneous push/pop
    push_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      push_ch = 8'h60 + 8'(i);
      tick();
    end
    push_ch = 8'h70;
    check("full_ready", 32'(push_ready), 32'd0);
    check("full_level", 32'(level), 32'd16);
    tick();
    check("full_hold_level", 32'(level), 32'd16);
    strobe(8'h60);
    check("full_pop_level", 32'(level), 32'd15);
    check("full_pop_ready", 32'(push_ready), 32'd1);
    tick();
    push_valid = 1'b0;
    check("refill_level", 32'(level), 32'd16);
    for (int i = 1; i < 16; i++) strobe(8'h60 + 8'(i));
    strobe(8'h70);
    check("drain_level", 32'(level), 32'd0);

    // Wrap-around with overlapping push/pop
    push1(8'h90);
    for (int i = 1; i < 40; i++) begin
      push_valid = 1'b1;
      push_ch    = 8'h90 + 8'(i);
      strobe(8'h90 + 8'(i - 1));
      push_valid = 1'b0;
    end
    check("wrap_level", 32'(level), 32'd1);
    strobe(8'hb7);
    check("wrap_level0", 32'(level), 32'd0);
    check("wrap_reads", reads_no_char, 32'd2);

    // Asynchronous reset between edges
    push1(8'ha1);
    push1(8'ha2);
    @(posedge clock);
    #2 reset = 1'b1;
    #1;
    check("async_uart_in_ch", 32'(uart_in_ch), 32'hff);
    check("async_level", 32'(level), 32'd0);
    check("async_ready", 32'(push_ready), 32'd1);
    check("async_reads", reads_no_char, 32'd0);
    tick();
    reset = 1'b0;
    tick();
    check("post_rst_level", 32'(level), 32'd0);

    // EOF handling
    push1(8'h31);
    push1(8'h32);
    push1(8'h33);
    push_eof = 1'b1;
    tick();
    push_eof = 1'b0;
    check("eof_ready", 32'(push_ready), 32'd0);
    check("eof_not_yet", 32'(eof_reached), 32'd0);
    push1(8'h34);
    check("eof_ignored_push", 32'(level), 32'd3);
    strobe(8'h31);
    strobe(8'h32);
    check("eof_draining", 32'(eof_reached), 32'd0);
    strobe(8'h33);
    check("eof_reached", 32'(eof_reached), 32'd1);
    check("eof_uart_in_ch", 32'(uart_in_ch), 32'hff);
    check("eof_level", 32'(level), 32'd0);
    strobe(8'hff);
    check("eof_reads", reads_no_char, 32'd1);

    repeat (2) tick();
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
`ifdef SIM_UART_IN_ECHO_EN
    check("echo_q_empty", 32'(echo_q.size()), 32'd0);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
